uart_frame_parser: RTL and testbench

Framed-command receiver sitting directly downstream of the UART block's receive side. It pops bytes from the UART RX FIFO over the UART's parallel bus (cs/we/oe/data), hunts for a start-of-frame byte, validates length and XOR checksum, buffers the payload, and only then replays it as an address-incrementing write stream to a register/memory port. Malformed, corrupted or stalled frames are dropped whole and reported on a status pulse.

---
 rtl/uart_frame_parser.sv | 195 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Framed-command receiver behind the UART RX FIFO: hunts SOF, checks LEN and XOR checksum,
// buffers the payload and replays it as an address-incrementing write stream.
//
// state    | meaning
// HUNT     | discard bytes until SOF
// GET_ADDR | next byte is the base address
// GET_LEN  | next byte is the payload length
// GET_DATA | collecting payload bytes into the buffer
// GET_CHK  | next byte is the XOR checksum
// COMMIT   | replaying buffered payload as writes; fetching paused
module uart_frame_parser #(
   parameter int                   DATA_SIZE      = 8,
   parameter int                   ADDR_WIDTH     = 8,
   parameter int                   MAX_LEN        = 16,
   parameter logic [DATA_SIZE-1:0] SOF            = 8'hA5,
   parameter int                   TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  uart_cs,
   output logic                  uart_oe,
   output logic                  uart_we,
   input  logic [DATA_SIZE-1:0]  uart_data,
   input  logic                  rx_empty,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_SIZE-1:0]  wr_data,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]        TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_SIZE-1:0] MAX_LEN_B = DATA_SIZE'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HUNT, S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_GET_CHK, S_COMMIT
   } state_t;
   typedef enum logic [1:0] {F_IDLE, F_REQ, F_GAP} fetch_t;

   state_t                state_q, state_d;
   fetch_t                fetch_q, fetch_d;
   logic [DATA_SIZE-1:0]  addr_q, addr_d, len_q, len_d, chk_q, chk_d;
   logic [IW-1:0]         idx_q, idx_d, idx_inc;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic                  byte_vld, counting, timeout, pay_we;
   logic                  wr_valid_d, frame_ok_d, frame_err_d;
   logic [ADDR_WIDTH-1:0] wr_addr_d;
   logic [DATA_SIZE-1:0]  wr_data_d;
   logic [1:0]            err_code_d;
   logic [DATA_SIZE-1:0]  pay_q [MAX_LEN];

   // A byte is captured on the edge that ends the one-cycle read strobe.
   assign byte_vld = (fetch_q == F_REQ);
   assign uart_cs  = byte_vld;
   assign uart_oe  = byte_vld;
   assign uart_we  = 1'b0;
   assign busy     = (state_q != S_HUNT);
   assign idx_inc  = idx_q + 1'b1;
   assign counting = state_q inside {S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_GET_CHK};
   assign timeout  = counting && !byte_vld && (tmr_q == TMR_LAST);

   always_comb begin
      fetch_d     = fetch_q;
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      chk_d       = chk_q;
      idx_d       = idx_q;
      tmr_d       = tmr_q;
      wr_valid_d  = wr_valid;
      wr_addr_d   = wr_addr;
      wr_data_d   = wr_data;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code;
      pay_we      = 1'b0;

      case (fetch_q)
         F_IDLE:  if (!rx_empty && state_q != S_COMMIT) fetch_d = F_REQ;
         F_REQ:   fetch_d = F_GAP;
         default: fetch_d = F_IDLE;
      endcase

      if (byte_vld || !counting) tmr_d = '0;
      else                       tmr_d = tmr_q + 1'b1;

      case (state_q)
         S_HUNT:
            if (byte_vld && uart_data == SOF) state_d = S_GET_ADDR;
         S_GET_ADDR:
            if (byte_vld) begin
               addr_d  = uart_data;
               chk_d   = uart_data;
               state_d = S_GET_LEN;
            end
         S_GET_LEN:
            if (byte_vld) begin
               if (uart_data == '0 || uart_data > MAX_LEN_B) begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'b01;
                  state_d     = S_HUNT;
               end else begin
                  len_d   = uart_data;
                  chk_d   = chk_q ^ uart_data;
                  idx_d   = '0;
                  state_d = S_GET_DATA;
               end
            end
         S_GET_DATA:
            if (byte_vld) begin
               pay_we = 1'b1;
               chk_d  = chk_q ^ uart_data;
               idx_d  = idx_inc;
               if (DATA_SIZE'(idx_q) == len_q - 1'b1) state_d = S_GET_CHK;
            end
         S_GET_CHK:
            if (byte_vld) begin
               if (uart_data == chk_q) begin
                  state_d    = S_COMMIT;
                  idx_d      = '0;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ADDR_WIDTH'(addr_q);
                  wr_data_d  = pay_q[0];
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'b10;
                  state_d     = S_HUNT;
               end
            end
         S_COMMIT:
            if (wr_valid && wr_ready) begin
               if (DATA_SIZE'(idx_q) == len_q - 1'b1) begin
                  wr_valid_d = 1'b0;
                  frame_ok_d = 1'b1;
                  err_code_d = 2'b00;
                  state_d    = S_HUNT;
               end else begin
                  idx_d     = idx_inc;
                  wr_addr_d = ADDR_WIDTH'(addr_q) + ADDR_WIDTH'(idx_inc);
                  wr_data_d = pay_q[idx_inc];
               end
            end
         default: state_d = S_HUNT;
      endcase

      if (timeout) begin
         frame_err_d = 1'b1;
         err_code_d  = 2'b11;
         state_d     = S_HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_HUNT;
         fetch_q   <= F_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         chk_q     <= '0;
         idx_q     <= '0;
         tmr_q     <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         state_q   <= state_d;
         fetch_q   <= fetch_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         chk_q     <= chk_d;
         idx_q     <= idx_d;
         tmr_q     <= tmr_d;
         wr_valid  <= wr_valid_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         frame_ok  <= frame_ok_d;
         frame_err <= frame_err_d;
         err_code  <= err_code_d;
      end
   end

   // Payload buffer needs no reset: it is always written before it is read.
   always_ff @(posedge clk) begin
      if (pay_we) pay_q[idx_q] <= uart_data;
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a queue-backed UART RX model feeds frames, and a
// scoreboard of expected (addr, data) writes is checked at every write handshake.
module tb_uart_frame_parser;
   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_cs, uart_oe, uart_we;
   logic [7:0] uart_data = 8'h00;
   logic       rx_empty = 1'b1;
   logic       wr_valid;
   logic       wr_ready = 1'b1;
   logic [7:0] wr_addr, wr_data;
   logic       frame_ok, frame_err;
   logic [1:0] err_code;
   logic       busy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          ok_cnt = 0, err_cnt = 0, wr_cnt = 0, ok_cyc = 0, err_cyc = 0;
   logic [1:0]  last_err = 2'b00;
   logic        pop_pending = 1'b0;
   logic [7:0]  rxq[$];
   logic [15:0] exp_q[$];
   int          cap_q[$];
   int          hs_q[$];

   uart_frame_parser #(
      .DATA_SIZE(8), .ADDR_WIDTH(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .uart_cs(uart_cs), .uart_oe(uart_oe), .uart_we(uart_we),
      .uart_data(uart_data), .rx_empty(rx_empty),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART RX model: the entry read during a strobe is popped in the following cycle.
   always @(negedge clk) begin
      if (pop_pending && rxq.size() != 0) void'(rxq.pop_front());
      pop_pending <= uart_cs && uart_oe && !uart_we;
      rx_empty    <= (rxq.size() == 0);
      uart_data   <= (rxq.size() != 0) ? rxq[0] : 8'h00;
   end

   always @(negedge clk) begin
      if (uart_cs) cap_q.push_back(cyc + 1);
      if (wr_valid && wr_ready) begin
         wr_cnt <= wr_cnt + 1;
         hs_q.push_back(cyc);
         check("write_expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            check("wr_addr", wr_addr, exp_q[0][15:8]);
            check("wr_data", wr_data, exp_q[0][7:0]);
            void'(exp_q.pop_front());
         end
      end
      if (frame_ok) begin
         ok_cnt <= ok_cnt + 1;
         ok_cyc <= cyc;
      end
      if (frame_err) begin
         err_cnt  <= err_cnt + 1;
         err_cyc  <= cyc;
         last_err <= err_code;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rxq.push_back(b);
   endtask

   task automatic good_frame();
      push(8'hA5); push(8'h10); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h13);
      exp_q.push_back(16'h1011);
      exp_q.push_back(16'h1122);
      exp_q.push_back(16'h1233);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((rxq.size() != 0 || busy) && n < 2000);
      if (n >= 2000) check(tag, rxq.size() + (busy ? 1 : 0), 0);
      repeat (4) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ok0, err0, wr0, n, e0;

      repeat (3) tick();
      check("reset_outputs",
            {uart_cs, uart_oe, uart_we, wr_valid, frame_ok, frame_err, busy, wr_addr, wr_data, err_code}, 0);
      rst = 1'b0;
      tick();

      // Good frame with wr_ready held high.
      ok0 = ok_cnt; err0 = err_cnt; hs_q.delete();
      good_frame();
      drain("good_drain");
      check("good_ok_count", ok_cnt - ok0, 1);
      check("good_err_count", err_cnt - err0, 0);
      check("good_err_code", err_code, 0);
      check("good_wr_count", hs_q.size(), 3);
      if (hs_q.size() == 3) begin
         check("good_back_to_back", hs_q[2] - hs_q[0], 2);
         check("good_ok_timing", ok_cyc - hs_q[2], 1);
      end
      check("good_sb_empty", exp_q.size(), 0);

      // Leading garbage.
      ok0 = ok_cnt; err0 = err_cnt;
      push(8'h00); push(8'hFF); push(8'h5A);
      good_frame();
      drain("garbage_drain");
      check("garbage_ok_count", ok_cnt - ok0, 1);
      check("garbage_err_count", err_cnt - err0, 0);
      check("garbage_sb_empty", exp_q.size(), 0);

      // Bad checksum, then a good frame.
      ok0 = ok_cnt; err0 = err_cnt; cap_q.delete();
      push(8'hA5); push(8'h10); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h14);
      good_frame();
      drain("chk_drain");
      check("chk_err_count", err_cnt - err0, 1);
      check("chk_err_code", last_err, 2'b10);
      check("chk_ok_count", ok_cnt - ok0, 1);
      check("chk_err_code_cleared", err_code, 2'b00);
      if (cap_q.size() >= 7) check("chk_err_timing", err_cyc, cap_q[6]);
      check("chk_sb_empty", exp_q.size(), 0);

      // LEN = 0; the next byte is a HUNT candidate.
      ok0 = ok_cnt; err0 = err_cnt; cap_q.delete();
      push(8'hA5); push(8'h10); push(8'h00);
      good_frame();
      drain("len0_drain");
      check("len0_err_count", err_cnt - err0, 1);
      check("len0_err_code", last_err, 2'b01);
      if (cap_q.size() >= 3) check("len0_err_timing", err_cyc, cap_q[2]);
      check("len0_ok_count", ok_cnt - ok0, 1);
      check("len0_sb_empty", exp_q.size(), 0);

      // LEN = 17 exceeds MAX_LEN.
      ok0 = ok_cnt; err0 = err_cnt; cap_q.delete();
      push(8'hA5); push(8'h10); push(8'h11);
      good_frame();
      drain("len17_drain");
      check("len17_err_count", err_cnt - err0, 1);
      check("len17_err_code", last_err, 2'b01);
      if (cap_q.size() >= 3) check("len17_err_timing", err_cyc, cap_q[2]);
      check("len17_ok_count", ok_cnt - ok0, 1);
      check("len17_sb_empty", exp_q.size(), 0);

      // Timeout after ADDR.
      ok0 = ok_cnt; err0 = err_cnt; cap_q.delete();
      push(8'hA5); push(8'h10);
      n = 0;
      while (err_cnt == err0 && n < 300) begin
         tick();
         n++;
      end
      check("to_err_count", err_cnt - err0, 1);
      check("to_err_code", last_err, 2'b11);
      if (cap_q.size() >= 2) check("to_latency", err_cyc - cap_q[1], TO);
      check("to_ok_count", ok_cnt - ok0, 0);
      drain("to_drain");

      // Byte captured on the expiry cycle wins over the timeout.
      ok0 = ok_cnt; err0 = err_cnt; cap_q.delete();
      push(8'hA5); push(8'h10);
      n = 0;
      while (cap_q.size() < 2 && n < 100) begin
         tick();
         n++;
      end
      e0 = (cap_q.size() >= 2) ? cap_q[1] : cyc;
      n = 0;
      while (cyc < e0 + TO - 2 && n < 300) begin
         tick();
         n++;
      end
      push(8'h01); push(8'h44); push(8'h55);
      exp_q.push_back(16'h1044);
      drain("late_drain");
      check("late_err_count", err_cnt - err0, 0);
      check("late_ok_count", ok_cnt - ok0, 1);
      if (cap_q.size() >= 3) check("late_byte_edge", cap_q[2] - e0, TO);
      check("late_sb_empty", exp_q.size(), 0);

      // Address wrap with a stalled consumer.
      ok0 = ok_cnt; cap_q.delete();
      wr_ready = 1'b0;
      push(8'hA5); push(8'hFF); push(8'h02); push(8'h5A); push(8'hC3); push(8'h64);
      exp_q.push_back(16'hFF5A);
      exp_q.push_back(16'h00C3);
      n = 0;
      while (!wr_valid && n < 200) begin
         tick();
         n++;
      end
      if (cap_q.size() >= 6) check("wrap_first_valid", cyc, cap_q[5]);
      repeat (5) begin
         check("stall_valid", wr_valid, 1);
         check("stall_addr", wr_addr, 8'hFF);
         check("stall_data", wr_data, 8'h5A);
         tick();
      end
      wr_ready = 1'b1;
      drain("wrap_drain");
      check("wrap_ok_count", ok_cnt - ok0, 1);
      check("wrap_sb_empty", exp_q.size(), 0);

      // Reset in the middle of COMMIT.
      ok0 = ok_cnt; wr0 = wr_cnt;
      wr_ready = 1'b0;
      good_frame();
      n = 0;
      while (!wr_valid && n < 200) begin
         tick();
         n++;
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_outputs",
            {uart_cs, uart_oe, uart_we, wr_valid, frame_ok, frame_err, busy, wr_addr, wr_data, err_code}, 0);
      exp_q.delete();
      wr_ready = 1'b1;
      repeat (20) tick();
      check("midrst_no_writes", wr_cnt - wr0, 0);
      check("midrst_no_ok", ok_cnt - ok0, 0);
      check("midrst_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
